// File: rtl/sysex_param_parser_pkg.sv
`default_nettype none
// ============================================================================
// sysex_param_parser_pkg : MIDI constants, bank codes, parser state enum
// Revision 1.0
// ============================================================================
package sysex_param_parser_pkg;

    localparam logic [7:0] SYX_START     = 8'hF0;
    localparam logic [7:0] SYX_END       = 8'hF7;
    localparam logic [7:0] RT_MIN        = 8'hF8;
    localparam logic [6:0] MFR_ID        = 7'h7D;
    localparam logic [6:0] CMD_PARAM     = 7'h01;
    localparam logic [6:0] DEV_BROADCAST = 7'h7F;

    localparam logic [2:0] BANK_ENV = 3'd0;
    localparam logic [2:0] BANK_OSC = 3'd1;
    localparam logic [2:0] BANK_M1  = 3'd2;
    localparam logic [2:0] BANK_M2  = 3'd3;
    localparam logic [2:0] BANK_COM = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MFR,
        S_DEV,
        S_CMD,
        S_BANK,
        S_ADR,
        S_DHI,
        S_DLO,
        S_EMIT,
        S_IGNORE
    } parse_state_t;

    function automatic logic bank_valid(input logic [6:0] value);
        return (value == {4'd0, BANK_ENV}) || (value == {4'd0, BANK_OSC}) ||
               (value == {4'd0, BANK_M1})  || (value == {4'd0, BANK_M2})  ||
               (value == {4'd0, BANK_COM});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysex_param_parser.sv
`default_nettype none
// ============================================================================
// sysex_param_parser : SysEx frame parser emitting synth parameter writes
// Revision 1.0
// ============================================================================
module sysex_param_parser
    import sysex_param_parser_pkg::*;
#(
    parameter logic [6:0] DEV_ID   = 7'h00,
    parameter int         DR_WIDTH = 1,
    parameter int         HOLD     = 8
) (
    input  logic       CLOCK_25,
    input  logic       iRST_N,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [2:0] bank_adr,
    output logic [6:0] param_adr,
    output logic [7:0] param_data,
    output logic       data_ready,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);
    localparam logic [3:0] DR_OFF    = 4'(HOLD - DR_WIDTH);

    parse_state_t state, state_nxt;
    logic [3:0]   hold_cnt, hold_nxt;
    logic [2:0]   bank_stage, bank_stage_nxt;
    logic [6:0]   adr_stage, adr_stage_nxt;
    logic         dhi_stage, dhi_stage_nxt;
    logic [2:0]   bank_adr_nxt;
    logic [6:0]   param_adr_nxt;
    logic [7:0]   param_data_nxt;
    logic         data_ready_nxt, frame_done_nxt, frame_err_nxt;
    logic         xfer;

    assign byte_ready = (state != S_EMIT);
    assign xfer       = byte_valid & byte_ready;

    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            hold_cnt   <= 4'd0;
            bank_stage <= 3'd0;
            adr_stage  <= 7'd0;
            dhi_stage  <= 1'b0;
            bank_adr   <= 3'd0;
            param_adr  <= 7'd0;
            param_data <= 8'd0;
            data_ready <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            bank_stage <= bank_stage_nxt;
            adr_stage  <= adr_stage_nxt;
            dhi_stage  <= dhi_stage_nxt;
            bank_adr   <= bank_adr_nxt;
            param_adr  <= param_adr_nxt;
            param_data <= param_data_nxt;
            data_ready <= data_ready_nxt;
            frame_done <= frame_done_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold_cnt;
        bank_stage_nxt = bank_stage;
        adr_stage_nxt  = adr_stage;
        dhi_stage_nxt  = dhi_stage;
        bank_adr_nxt   = bank_adr;
        param_adr_nxt  = param_adr;
        param_data_nxt = param_data;
        data_ready_nxt = 1'b0;
        frame_done_nxt = 1'b0;
        frame_err_nxt  = 1'b0;

        if (state == S_EMIT) begin
            // data_ready trails the hold count so both end from one counter
            data_ready_nxt = (hold_cnt > DR_OFF);
            if (hold_cnt == 4'd0) begin
                state_nxt = S_ADR;
            end else begin
                hold_nxt = hold_cnt - 4'd1;
            end
        end else if (xfer) begin
            if (byte_in >= RT_MIN) begin
                state_nxt = state;
            end else if (byte_in == SYX_START) begin
                state_nxt     = S_MFR;
                frame_err_nxt = (state != S_IDLE) && (state != S_IGNORE);
            end else if (byte_in == SYX_END) begin
                state_nxt      = S_IDLE;
                frame_done_nxt = (state == S_ADR);
                frame_err_nxt  = (state != S_IDLE) && (state != S_IGNORE) &&
                                 (state != S_ADR);
            end else if (byte_in[7]) begin
                if ((state != S_IDLE) && (state != S_IGNORE)) begin
                    state_nxt     = S_IDLE;
                    frame_err_nxt = 1'b1;
                end
            end else begin
                case (state)
                    S_MFR:  state_nxt = (byte_in[6:0] == MFR_ID) ? S_DEV : S_IGNORE;
                    S_DEV:  state_nxt = ((byte_in[6:0] == DEV_ID) ||
                                         (byte_in[6:0] == DEV_BROADCAST)) ? S_CMD : S_IGNORE;
                    S_CMD:  state_nxt = (byte_in[6:0] == CMD_PARAM) ? S_BANK : S_IGNORE;
                    S_BANK: begin
                        if (bank_valid(byte_in[6:0])) begin
                            bank_stage_nxt = byte_in[2:0];
                            state_nxt      = S_ADR;
                        end else begin
                            state_nxt = S_IGNORE;
                        end
                    end
                    S_ADR: begin
                        adr_stage_nxt = byte_in[6:0];
                        state_nxt     = S_DHI;
                    end
                    S_DHI: begin
                        dhi_stage_nxt = byte_in[0];
                        state_nxt     = S_DLO;
                    end
                    S_DLO: begin
                        // outputs move together so the decoder never sees a mixed record
                        bank_adr_nxt   = bank_stage;
                        param_adr_nxt  = adr_stage;
                        param_data_nxt = {dhi_stage, byte_in[6:0]};
                        data_ready_nxt = 1'b1;
                        hold_nxt       = HOLD_LOAD;
                        state_nxt      = S_EMIT;
                    end
                    default: state_nxt = state;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysex_param_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sysex_param_parser : directed frames checked against a frame-level model
// Revision 1.0
// ============================================================================
module tb_sysex_param_parser;

    localparam int DR_WIDTH = 2;
    localparam int HOLD     = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic [2:0] bank_adr;
    logic [6:0] param_adr;
    logic [7:0] param_data;
    logic       data_ready, frame_done, frame_err;

    sysex_param_parser #(.DEV_ID(7'h00), .DR_WIDTH(DR_WIDTH), .HOLD(HOLD)) dut (
        .CLOCK_25  (clk),
        .iRST_N    (rst_n),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .bank_adr  (bank_adr),
        .param_adr (param_adr),
        .param_data(param_data),
        .data_ready(data_ready),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #20 clk = ~clk;

    int vec_cnt = 0;
    int bad_cnt = 0;

    // frame-level model: bytes of the open frame kept in a queue
    int         cyc = 0;
    int         busy_end = -1;
    int         dr_end = -1;
    int         mode = 0;             // 0 outside, 1 in frame, 2 ignoring
    logic [7:0] q[$];
    logic [2:0] m_bank = 3'd0;
    logic [6:0] m_adr = 7'd0;
    logic [7:0] m_data = 8'd0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;

    task automatic model_byte(input logic [7:0] b);
        int n;
        if (b >= 8'hF8) return;
        if (b == 8'hF0) begin
            m_err = (mode == 1);
            mode  = 1;
            q.delete();
        end else if (b == 8'hF7) begin
            if (mode == 1) begin
                n = q.size();
                if (n >= 4 && (n - 4) % 3 == 0) m_done = 1'b1;
                else m_err = 1'b1;
            end
            mode = 0;
        end else if (b[7]) begin
            if (mode == 1) begin
                m_err = 1'b1;
                mode  = 0;
            end
        end else if (mode == 1) begin
            q.push_back(b);
            n = q.size();
            if (n == 1) begin
                if (b != 8'h7D) mode = 2;
            end else if (n == 2) begin
                if (b != 8'h00 && b != 8'h7F) mode = 2;
            end else if (n == 3) begin
                if (b != 8'h01) mode = 2;
            end else if (n == 4) begin
                if (!(b inside {8'd0, 8'd1, 8'd2, 8'd3, 8'd5})) mode = 2;
            end else if ((n - 4) % 3 == 0) begin
                m_bank   = q[3][2:0];
                m_adr    = q[n-3][6:0];
                m_data   = {q[n-2][0], q[n-1][6:0]};
                dr_end   = cyc + DR_WIDTH;
                busy_end = cyc + HOLD;
            end
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mode = 0; q.delete();
                busy_end = -1; dr_end = -1;
                m_bank = 3'd0; m_adr = 7'd0; m_data = 8'd0;
                m_done = 1'b0; m_err = 1'b0;
            end else begin
                m_done = 1'b0;
                m_err  = 1'b0;
                if (byte_valid && (cyc > busy_end)) model_byte(byte_in);
                cyc++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // observed strobe log and pulse counters
    int          rise_cnt = 0, done_cnt = 0, err_cnt = 0, low_cnt = 0;
    int          rise_prev = 0, rise_last = 0;
    logic        prev_dr = 1'b0;
    logic [17:0] slog[$];

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("byte_ready", int'(byte_ready), int'(cyc > busy_end));
            chk("data_ready", int'(data_ready), int'(cyc <= dr_end));
            chk("frame_done", int'(frame_done), int'(m_done));
            chk("frame_err",  int'(frame_err),  int'(m_err));
            chk("bank_adr",   int'(bank_adr),   int'(m_bank));
            chk("param_adr",  int'(param_adr),  int'(m_adr));
            chk("param_data", int'(param_data), int'(m_data));
            if (data_ready && !prev_dr) begin
                rise_cnt++;
                rise_prev = rise_last;
                rise_last = cyc;
                slog.push_back({bank_adr, param_adr, param_data});
            end
            prev_dr = data_ready;
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
            if (!byte_ready) low_cnt++;
        end
    endtask

    logic [7:0] frm[$];
    int s_rise, s_done, s_err, s_low;

    task automatic snap();
        s_rise = rise_cnt; s_done = done_cnt; s_err = err_cnt; s_low = low_cnt;
    endtask

    task automatic send(input logic [7:0] b);
        int budget;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        budget     = 40;
        while (!byte_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!byte_ready) chk("byte_ready_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame();
        foreach (frm[i]) send(frm[i]);
        idle(HOLD + 10);
    endtask

    task automatic chk_counts(input string name, input int rises, input int dones, input int errs);
        chk({name, "_strobes"}, rise_cnt - s_rise, rises);
        chk({name, "_done"},    done_cnt - s_done, dones);
        chk({name, "_err"},     err_cnt - s_err, errs);
    endtask

    task automatic chk_strobe(input string name, input int idx, input logic [17:0] exp);
        if (idx < slog.size()) chk(name, int'(slog[idx]), int'(exp));
        else chk({name, "_missing"}, 0, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] single[$];
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_byte_ready", int'(byte_ready), 1);
        chk("rst_data_ready", int'(data_ready), 0);
        chk("rst_param_data", int'(param_data), 0);
        #2 rst_n = 1'b1;

        // single record
        single = '{8'hF0, 8'h7D, 8'h00, 8'h01, 8'h02, 8'h10, 8'h01, 8'h23, 8'hF7};
        frm = single;
        snap(); send_frame();
        chk_counts("single", 1, 1, 0);
        chk_strobe("single_rec", s_rise, {3'd2, 7'h10, 8'hA3});
        chk("single_ready_low", low_cnt - s_low, 8);

        // two records reusing bank 5, broadcast device
        frm = '{8'hF0, 8'h7D, 8'h7F, 8'h01, 8'h05, 8'h00, 8'h00, 8'h7F,
                8'h01, 8'h01, 8'h05, 8'hF7};
        snap(); send_frame();
        chk_counts("multi", 2, 1, 0);
        chk_strobe("multi_rec0", s_rise, {3'd5, 7'h00, 8'h7F});
        chk_strobe("multi_rec1", s_rise + 1, {3'd5, 7'h01, 8'h85});
        chk("multi_spacing_ge11", int'((rise_last - rise_prev) >= 11), 1);

        // wrong device
        frm = '{8'hF0, 8'h7D, 8'h03, 8'h01, 8'h02, 8'h10, 8'h01, 8'h23, 8'hF7};
        snap(); send_frame();
        chk_counts("wrongdev", 0, 0, 0);

        // bad bank, then a valid frame
        frm = '{8'hF0, 8'h7D, 8'h00, 8'h01, 8'h04, 8'h10, 8'h01, 8'h23, 8'hF7};
        frm = {frm, single};
        snap(); send_frame();
        chk_counts("bank4", 1, 1, 0);
        chk_strobe("bank4_rec", s_rise, {3'd2, 7'h10, 8'hA3});

        // F0 abort restarts the frame
        frm = '{8'hF0, 8'h7D, 8'h00, 8'h01, 8'h01, 8'h20,
                8'hF0, 8'h7D, 8'h00, 8'h01, 8'h03, 8'h11, 8'h00, 8'h42, 8'hF7};
        snap(); send_frame();
        chk_counts("abort_f0", 1, 1, 1);
        chk_strobe("abort_f0_rec", s_rise, {3'd3, 7'h11, 8'h42});

        // F7 in the middle of a record
        frm = '{8'hF0, 8'h7D, 8'h00, 8'h01, 8'h01, 8'h20, 8'h05, 8'hF7};
        snap(); send_frame();
        chk_counts("abort_f7", 0, 0, 1);

        // real-time bytes between every byte
        frm.delete();
        foreach (single[i]) begin
            frm.push_back(single[i]);
            if (i < single.size() - 1) begin
                frm.push_back(8'hF8);
                frm.push_back(8'hFE);
            end
        end
        snap(); send_frame();
        chk_counts("realtime", 1, 1, 0);
        chk_strobe("realtime_rec", s_rise, {3'd2, 7'h10, 8'hA3});
        chk("realtime_ready_low", low_cnt - s_low, 8);

        // reset while data_ready is still high
        frm = '{8'hF0, 8'h7D, 8'h00, 8'h01, 8'h02, 8'h10, 8'h01, 8'h23};
        foreach (frm[i]) send(frm[i]);
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_data_ready", int'(data_ready), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data_ready", int'(data_ready), 0);
        chk("mid_rst_byte_ready", int'(byte_ready), 1);
        chk("mid_rst_outputs", int'({bank_adr, param_adr, param_data}), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        frm = '{8'hF0, 8'h7D, 8'h7F, 8'h01, 8'h00, 8'h05, 8'h00, 8'h11, 8'hF7};
        snap(); send_frame();
        chk_counts("post_rst", 1, 1, 0);
        chk_strobe("post_rst_rec", s_rise, {3'd0, 7'h05, 8'h11});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
